// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter sharing one mux4 datapath between four requesters.
// Optional hold-limit timeout compiled in with MUX4_ARB_TIMEOUT_EN.
module mux4_rr_arbiter #(
    parameter int NB_SELECT = 2,
    parameter int MAX_HOLD  = 16
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic [3:0]           i_req,
    output logic [3:0]           o_gnt,
    output logic [NB_SELECT-1:0] o_sel,
    output logic                 o_busy
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

    if (NB_SELECT != 2) begin : g_bad_select
        $error("mux4_rr_arbiter: NB_SELECT must be 2");
    end
    if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_hold
        $error("mux4_rr_arbiter: MAX_HOLD must be within 2..255");
    end

    logic [0:0] state_q, state_d;
    logic [1:0] ptr_q, ptr_d;
    logic [3:0] gnt_q, gnt_d;
    logic [1:0] sel_q, sel_d;

    // Returns {found, index} of the first set bit of req in order ptr, ptr+1, ...
    function automatic logic [2:0] pick(input logic [3:0] req, input logic [1:0] ptr);
        logic       found;
        logic [1:0] idx;
        logic [1:0] cand;
        found = 1'b0;
        idx   = 2'd0;
        for (int unsigned i = 0; i < 4; i++) begin
            cand = ptr + 2'(i);
            if (!found && req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
        return {found, idx};
    endfunction

    logic [2:0] any_pick;
    logic [2:0] oth_pick;
    logic [3:0] other_req;
    logic       handoff;

    assign other_req = i_req & ~gnt_q;
    assign any_pick  = pick(i_req, ptr_q);
    assign oth_pick  = pick(other_req, ptr_q);

`ifdef MUX4_ARB_TIMEOUT_EN
    logic [7:0] cnt_q, cnt_d;
    logic       hold_expired;
    assign hold_expired = (cnt_q == 8'(MAX_HOLD - 1)) && (|other_req);
`else
    logic hold_expired;
    assign hold_expired = 1'b0;
`endif

    assign handoff = !i_req[sel_q] || hold_expired;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        sel_d   = sel_q;
`ifdef MUX4_ARB_TIMEOUT_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (any_pick[2]) begin
                    state_d = ST_GRANT;
                    gnt_d   = 4'b0001 << any_pick[1:0];
                    sel_d   = any_pick[1:0];
                    ptr_d   = any_pick[1:0] + 2'd1;
`ifdef MUX4_ARB_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            default: begin
                // The owner's bit is masked out, so its own request never wins the handoff.
                if (handoff) begin
                    if (oth_pick[2]) begin
                        gnt_d = 4'b0001 << oth_pick[1:0];
                        sel_d = oth_pick[1:0];
                        ptr_d = oth_pick[1:0] + 2'd1;
`ifdef MUX4_ARB_TIMEOUT_EN
                        cnt_d = '0;
`endif
                    end else begin
                        state_d = ST_IDLE;
                        gnt_d   = '0;
                    end
                end
`ifdef MUX4_ARB_TIMEOUT_EN
                else if (cnt_q != 8'(MAX_HOLD - 1)) begin
                    cnt_d = cnt_q + 8'd1;
                end
`endif
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            gnt_q   <= '0;
            sel_q   <= '0;
`ifdef MUX4_ARB_TIMEOUT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
`ifdef MUX4_ARB_TIMEOUT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    assign o_gnt  = gnt_q;
    assign o_sel  = NB_SELECT'(sel_q);
    assign o_busy = (state_q == ST_GRANT);

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed self-checking bench for mux4_rr_arbiter (MAX_HOLD=4 so the
// MUX4_ARB_TIMEOUT_EN build can be exercised with the same file).
module tb_mux4_rr_arbiter;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       busy;

    int total;
    int bad;

    mux4_rr_arbiter #(.NB_SELECT(2), .MAX_HOLD(4)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .i_req   (req),
        .o_gnt   (gnt),
        .o_sel   (sel),
        .o_busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = 4'b0000;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req = 4'b1111;
        tick();
        total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL reset_gnt got=%b exp=%b", gnt, 4'b0000); end
        total++; if (sel !== 2'd0) begin bad++; $display("FAIL reset_sel got=%0d exp=%0d", sel, 0); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=%b", busy, 1'b0); end
        rst = 1'b0;
        tick();
        total++; if (gnt !== 4'b0001) begin bad++; $display("FAIL post_reset_gnt got=%b exp=%b", gnt, 4'b0001); end
        total++; if (sel !== 2'd0) begin bad++; $display("FAIL post_reset_sel got=%0d exp=%0d", sel, 0); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL post_reset_busy got=%b exp=%b", busy, 1'b1); end
    endtask

    task automatic test_single();
        do_reset();
        req = 4'b0100;
        tick();
        total++; if (gnt !== 4'b0100) begin bad++; $display("FAIL single_gnt got=%b exp=%b", gnt, 4'b0100); end
        total++; if (sel !== 2'd2) begin bad++; $display("FAIL single_sel got=%0d exp=%0d", sel, 2); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_busy got=%b exp=%b", busy, 1'b1); end
        req = 4'b0000;
        tick();
        total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL single_rel_gnt got=%b exp=%b", gnt, 4'b0000); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_rel_busy got=%b exp=%b", busy, 1'b0); end
        total++; if (sel !== 2'd2) begin bad++; $display("FAIL single_rel_sel got=%0d exp=%0d", sel, 2); end
        tick();
        total++; if (sel !== 2'd2) begin bad++; $display("FAIL idle_sel_hold got=%0d exp=%0d", sel, 2); end
    endtask

    task automatic test_fairness();
        logic [3:0] req_seq [5];
        logic [3:0] exp_gnt [5];
        logic [1:0] exp_sel [5];
        req_seq = '{4'b1111, 4'b1110, 4'b1101, 4'b1011, 4'b0111};
        exp_gnt = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        exp_sel = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            req = req_seq[i];
            tick();
            total++; if (gnt !== exp_gnt[i]) begin bad++; $display("FAIL fair_gnt[%0d] got=%b exp=%b", i, gnt, exp_gnt[i]); end
            total++; if (sel !== exp_sel[i]) begin bad++; $display("FAIL fair_sel[%0d] got=%0d exp=%0d", i, sel, exp_sel[i]); end
            total++; if (busy !== 1'b1) begin bad++; $display("FAIL fair_busy[%0d] got=%b exp=%b", i, busy, 1'b1); end
        end
    endtask

    task automatic test_rotation();
        do_reset();
        req = 4'b0010;
        tick();
        total++; if (gnt !== 4'b0010) begin bad++; $display("FAIL rot_first_gnt got=%b exp=%b", gnt, 4'b0010); end
        req = 4'b0000;
        tick();
        total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL rot_idle_gnt got=%b exp=%b", gnt, 4'b0000); end
        total++; if (sel !== 2'd1) begin bad++; $display("FAIL rot_idle_sel got=%0d exp=%0d", sel, 1); end
        req = 4'b1001;
        tick();
        total++; if (gnt !== 4'b1000) begin bad++; $display("FAIL rot_to3_gnt got=%b exp=%b", gnt, 4'b1000); end
        total++; if (sel !== 2'd3) begin bad++; $display("FAIL rot_to3_sel got=%0d exp=%0d", sel, 3); end
        tick();
        total++; if (gnt !== 4'b1000) begin bad++; $display("FAIL rot_hold3_gnt got=%b exp=%b", gnt, 4'b1000); end
        req = 4'b0001;
        tick();
        total++; if (gnt !== 4'b0001) begin bad++; $display("FAIL rot_to0_gnt got=%b exp=%b", gnt, 4'b0001); end
        total++; if (sel !== 2'd0) begin bad++; $display("FAIL rot_to0_sel got=%0d exp=%0d", sel, 0); end
    endtask

    task automatic test_hold_limit();
        do_reset();
        req = 4'b0001;
        tick();
        total++; if (gnt !== 4'b0001) begin bad++; $display("FAIL hold_start_gnt got=%b exp=%b", gnt, 4'b0001); end
        req = 4'b0101;
`ifdef MUX4_ARB_TIMEOUT_EN
        for (int i = 1; i <= 3; i++) begin
            tick();
            total++; if (gnt !== 4'b0001) begin bad++; $display("FAIL hold_keep_gnt[%0d] got=%b exp=%b", i, gnt, 4'b0001); end
        end
        tick();
        total++; if (gnt !== 4'b0100) begin bad++; $display("FAIL timeout_gnt got=%b exp=%b", gnt, 4'b0100); end
        total++; if (sel !== 2'd2) begin bad++; $display("FAIL timeout_sel got=%0d exp=%0d", sel, 2); end
`else
        for (int i = 1; i <= 10; i++) begin
            tick();
            total++; if (gnt !== 4'b0001) begin bad++; $display("FAIL hold_keep_gnt[%0d] got=%b exp=%b", i, gnt, 4'b0001); end
        end
        req = 4'b0100;
        tick();
        total++; if (gnt !== 4'b0100) begin bad++; $display("FAIL hold_release_gnt got=%b exp=%b", gnt, 4'b0100); end
        total++; if (sel !== 2'd2) begin bad++; $display("FAIL hold_release_sel got=%0d exp=%0d", sel, 2); end
`endif
    endtask

    task automatic test_reset_mid_grant();
        do_reset();
        req = 4'b1000;
        tick();
        total++; if (gnt !== 4'b1000) begin bad++; $display("FAIL mid_pre_gnt got=%b exp=%b", gnt, 4'b1000); end
        rst = 1'b1;
        tick();
        total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL mid_rst_gnt got=%b exp=%b", gnt, 4'b0000); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_rst_busy got=%b exp=%b", busy, 1'b0); end
        total++; if (sel !== 2'd0) begin bad++; $display("FAIL mid_rst_sel got=%0d exp=%0d", sel, 0); end
        rst = 1'b0;
        req = 4'b1010;
        tick();
        total++; if (gnt !== 4'b0010) begin bad++; $display("FAIL mid_after_gnt got=%b exp=%b", gnt, 4'b0010); end
        total++; if (sel !== 2'd1) begin bad++; $display("FAIL mid_after_sel got=%0d exp=%0d", sel, 1); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        req   = 4'b0000;
        test_reset();
        test_single();
        test_fairness();
        test_rotation();
        test_hold_limit();
        test_reset_mid_grant();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
